// File: rtl/pe_array_ctrl.sv
// Command initiator for the Life PE array: turns host write/read/step/run
// operations into cycle-exact PE command sequences and returns one response per operation.
module pe_array_ctrl #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int CMD_BITS   = 2,
    parameter int STATE_BITS = 1,
    parameter int GEN_BITS   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    // Both channels: a transfer happens on a rising edge where valid & ready are high;
    // the initiator holds valid and its payload unchanged until that edge.
    input  logic                    host_valid,
    output logic                    host_ready,
    input  logic [1:0]              host_op,
    input  logic [$clog2(ROWS)-1:0] host_row,
    input  logic [$clog2(COLS)-1:0] host_col,
    input  logic [STATE_BITS-1:0]   host_wdata,
    input  logic [GEN_BITS-1:0]     host_gens,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [STATE_BITS-1:0]   resp_data,
    output logic [GEN_BITS-1:0]     resp_gens,
    output logic                    resp_stable,
    output logic                    resp_err,
    output logic [CMD_BITS-1:0]     pe_cmd,
    output logic [ROWS-1:0]         pe_rsel,
    output logic [COLS-1:0]         pe_csel,
    output logic [STATE_BITS-1:0]   pe_state_in,
    input  logic [STATE_BITS-1:0]   pe_state_out,
    input  logic                    pe_active_any,
    output logic [1:0]              dbg_state
);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd3;

    localparam logic [CMD_BITS-1:0] CMD_NOP     = CMD_BITS'(0);
    localparam logic [CMD_BITS-1:0] CMD_PROCESS = CMD_BITS'(1);
    localparam logic [CMD_BITS-1:0] CMD_READ    = CMD_BITS'(2);
    localparam logic [CMD_BITS-1:0] CMD_WRITE   = CMD_BITS'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]            op_q, op_d;
    logic                  err_q, err_d;
    logic [GEN_BITS-1:0]   gens_q, gens_d;
    logic [GEN_BITS-1:0]   cnt_q, cnt_d;
    logic [GEN_BITS-1:0]   cnt_inc;

    logic [CMD_BITS-1:0]   cmd_d;
    logic [ROWS-1:0]       rsel_d, row_onehot;
    logic [COLS-1:0]       csel_d, col_onehot;
    logic [STATE_BITS-1:0] sin_d;
    logic                  rvalid_d;
    logic [STATE_BITS-1:0] rdata_d;
    logic [GEN_BITS-1:0]   rgens_d;
    logic                  rstable_d;
    logic                  rerr_d;

    logic sel_err;
    logic run_zero;
    logic exec_done;

    // The range check only bites when ROWS/COLS are not powers of two.
    assign sel_err    = (32'(host_row) >= ROWS) || (32'(host_col) >= COLS);
    assign row_onehot = ROWS'(1) << host_row;
    assign col_onehot = COLS'(1) << host_col;
    assign run_zero   = (host_op == OP_RUN) && (host_gens == '0);

    // STEP and RUN (op bit 1 set) are the PROCESS-issuing operations.
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + GEN_BITS'(1);
    assign exec_done = (op_q != OP_RUN) || !pe_active_any || (cnt_inc == gens_q);

    assign host_ready = (state_q == S_IDLE);
    assign dbg_state  = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (host_valid) state_d = run_zero ? S_RESP : S_EXEC;
            S_EXEC:  if (exec_done)  state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        err_d     = err_q;
        gens_d    = gens_q;
        cnt_d     = cnt_q;
        cmd_d     = pe_cmd;
        rsel_d    = pe_rsel;
        csel_d    = pe_csel;
        sin_d     = pe_state_in;
        rvalid_d  = resp_valid;
        rdata_d   = resp_data;
        rgens_d   = resp_gens;
        rstable_d = resp_stable;
        rerr_d    = resp_err;
        case (state_q)
            S_IDLE: begin
                if (host_valid) begin
                    op_d      = host_op;
                    gens_d    = host_gens;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    rdata_d   = '0;
                    rgens_d   = '0;
                    rstable_d = 1'b0;
                    rerr_d    = 1'b0;
                    if (host_op == OP_WRITE || host_op == OP_READ) begin
                        // Out-of-range targets still issue the command, just with no PE selected.
                        cmd_d  = (host_op == OP_WRITE) ? CMD_WRITE : CMD_READ;
                        err_d  = sel_err;
                        rsel_d = sel_err ? '0 : row_onehot;
                        csel_d = sel_err ? '0 : col_onehot;
                        sin_d  = (host_op == OP_WRITE) ? host_wdata : '0;
                    end else begin
                        rsel_d   = '0;
                        csel_d   = '0;
                        sin_d    = '0;
                        cmd_d    = run_zero ? CMD_NOP : CMD_PROCESS;
                        rvalid_d = run_zero;
                    end
                end
            end
            S_EXEC: begin
                if (op_q[1]) cnt_d = cnt_inc;
                if (exec_done) begin
                    cmd_d     = CMD_NOP;
                    rsel_d    = '0;
                    csel_d    = '0;
                    sin_d     = '0;
                    rvalid_d  = 1'b1;
                    rerr_d    = err_q;
                    rdata_d   = (op_q == OP_READ && !err_q) ? pe_state_out : '0;
                    rgens_d   = op_q[1] ? cnt_inc : '0;
                    rstable_d = op_q[1] & ~pe_active_any;
                end
            end
            S_RESP: begin
                if (resp_ready) rvalid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q        <= '0;
            err_q       <= 1'b0;
            gens_q      <= '0;
            cnt_q       <= '0;
            pe_cmd      <= CMD_NOP;
            pe_rsel     <= '0;
            pe_csel     <= '0;
            pe_state_in <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_gens   <= '0;
            resp_stable <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            op_q        <= op_d;
            err_q       <= err_d;
            gens_q      <= gens_d;
            cnt_q       <= cnt_d;
            pe_cmd      <= cmd_d;
            pe_rsel     <= rsel_d;
            pe_csel     <= csel_d;
            pe_state_in <= sin_d;
            resp_valid  <= rvalid_d;
            resp_data   <= rdata_d;
            resp_gens   <= rgens_d;
            resp_stable <= rstable_d;
            resp_err    <= rerr_d;
        end
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl against an 8x8 Life array model, plus a 6x6
// instance in lockstep for out-of-range target handling.
module tb_pe_array_ctrl;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;
    localparam logic [1:0] C_NOP    = 2'd0;
    localparam logic [1:0] C_PROC   = 2'd1;
    localparam logic [1:0] C_READ   = 2'd2;
    localparam logic [1:0] C_WRITE  = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_valid = 1'b0;
    logic [1:0]  host_op = '0;
    logic [2:0]  host_row = '0;
    logic [2:0]  host_col = '0;
    logic [0:0]  host_wdata = '0;
    logic [15:0] host_gens = '0;
    logic        resp_ready = 1'b0;

    logic        host_ready, resp_valid, resp_stable, resp_err, pe_active_any;
    logic [0:0]  resp_data, pe_state_in, pe_state_out;
    logic [15:0] resp_gens;
    logic [1:0]  pe_cmd, dbg_state;
    logic [7:0]  pe_rsel, pe_csel;

    logic        s_host_ready, s_resp_valid, s_resp_stable, s_resp_err;
    logic [0:0]  s_resp_data, s_pe_state_in;
    logic [0:0]  s_pe_state_out = 1'b1;
    logic [15:0] s_resp_gens;
    logic [1:0]  s_pe_cmd, s_dbg_state;
    logic [5:0]  s_pe_rsel, s_pe_csel;

    logic [63:0] grid = '0;
    logic        clear_req = 1'b0;

    int checks = 0;
    int passes = 0;

    int lat, proc, gaps, unstable;
    logic [1:0]  f_cmd, fs_cmd;
    logic [7:0]  f_rsel, f_csel;
    logic [5:0]  fs_rsel, fs_csel;
    logic        f_sin;
    logic        r_data, r_stable, r_err, rs_data, rs_err;
    logic [15:0] r_gens;

    always #5 clk = ~clk;

    pe_array_ctrl #(.ROWS(8), .COLS(8)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready), .host_op(host_op),
        .host_row(host_row), .host_col(host_col), .host_wdata(host_wdata), .host_gens(host_gens),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_gens(resp_gens), .resp_stable(resp_stable), .resp_err(resp_err),
        .pe_cmd(pe_cmd), .pe_rsel(pe_rsel), .pe_csel(pe_csel), .pe_state_in(pe_state_in),
        .pe_state_out(pe_state_out), .pe_active_any(pe_active_any), .dbg_state(dbg_state)
    );

    pe_array_ctrl #(.ROWS(6), .COLS(6)) dut_s (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(s_host_ready), .host_op(host_op),
        .host_row(host_row), .host_col(host_col), .host_wdata(host_wdata), .host_gens(host_gens),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_data(s_resp_data),
        .resp_gens(s_resp_gens), .resp_stable(s_resp_stable), .resp_err(s_resp_err),
        .pe_cmd(s_pe_cmd), .pe_rsel(s_pe_rsel), .pe_csel(s_pe_csel), .pe_state_in(s_pe_state_in),
        .pe_state_out(s_pe_state_out), .pe_active_any(pe_active_any), .dbg_state(s_dbg_state)
    );

    // Life rule on a bounded 8x8 board; cells beyond the edge are dead.
    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                            cnt += int'(g[(r + dr) * 8 + c + dc]);
                n[r * 8 + c] = (cnt == 3) || (cnt == 2 && g[r * 8 + c]);
            end
        end
        return n;
    endfunction

    always_comb begin
        pe_state_out = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (pe_cmd == C_READ && pe_rsel[r] && pe_csel[c]) pe_state_out = pe_state_out | grid[r * 8 + c];
        pe_active_any = (pe_cmd == C_PROC) && (life_next(grid) != grid);
    end

    always @(posedge clk) begin
        if (clear_req) grid <= '0;
        else if (pe_cmd == C_WRITE) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    if (pe_rsel[r] && pe_csel[c]) grid[r * 8 + c] <= pe_state_in[0];
        end else if (pe_cmd == C_PROC) grid <= life_next(grid);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issues one operation, records the first EXEC cycle and the response, then
    // holds resp_ready low for `hold` cycles before completing the handshake.
    task automatic do_op(input logic [1:0] op, input int row, input int col, input logic wd,
                         input int gens, input int hold);
        int w;
        @(negedge clk);
        host_op = op; host_row = 3'(row); host_col = 3'(col);
        host_wdata = wd; host_gens = 16'(gens); host_valid = 1'b1;
        w = 0;
        while (!host_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!host_ready) check("accept_timeout", 32'(host_ready), 32'd1);
        @(posedge clk); #1;
        host_valid = 1'b0;
        lat = 1; proc = 0; gaps = 0; unstable = 0;
        f_cmd = C_NOP; f_rsel = '0; f_csel = '0; f_sin = 1'b0;
        fs_cmd = C_NOP; fs_rsel = '0; fs_csel = '0;
        while (!resp_valid && lat < 400) begin
            if (lat == 1) begin
                f_cmd = pe_cmd; f_rsel = pe_rsel; f_csel = pe_csel; f_sin = pe_state_in[0];
                fs_cmd = s_pe_cmd; fs_rsel = s_pe_rsel; fs_csel = s_pe_csel;
            end
            if (pe_cmd == C_PROC) proc++;
            if (pe_cmd == C_NOP) gaps++;
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
        r_data = resp_data[0]; r_gens = resp_gens; r_stable = resp_stable; r_err = resp_err;
        rs_data = s_resp_data[0]; rs_err = s_resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || host_ready !== 1'b0 || pe_cmd !== C_NOP ||
                resp_data[0] !== r_data || resp_gens !== r_gens ||
                resp_stable !== r_stable || resp_err !== r_err) unstable++;
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic clear_grid();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
    endtask

    task automatic put(input int r, input int c);
        do_op(OP_WRITE, r, c, 1'b1, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset asserts between edges; outputs must clear with no clock edge.
        #1 rst = 1'b0;
        #2;
        check("rst0_cmd", 32'(pe_cmd), 32'(C_NOP));
        check("rst0_resp_valid", 32'(resp_valid), 32'd0);
        check("rst0_rsel", 32'(pe_rsel), 32'd0);
        check("rst0_gens", 32'(resp_gens), 32'd0);
        check("rst0_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst0_host_ready", 32'(host_ready), 32'd1);

        // Write then read a single cell.
        clear_grid();
        do_op(OP_WRITE, 2, 3, 1'b1, 0, 0);
        check("wr_cmd", 32'(f_cmd), 32'(C_WRITE));
        check("wr_rsel", 32'(f_rsel), 32'h04);
        check("wr_csel", 32'(f_csel), 32'h08);
        check("wr_sin", 32'(f_sin), 32'd1);
        check("wr_lat", 32'(lat), 32'd2);
        check("wr_err", 32'(r_err), 32'd0);
        do_op(OP_READ, 2, 3, 1'b0, 0, 0);
        check("rd_cmd", 32'(f_cmd), 32'(C_READ));
        check("rd_data", 32'(r_data), 32'd1);
        check("rd_err", 32'(r_err), 32'd0);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_small_err", 32'(rs_err), 32'd0);
        check("rd_small_data", 32'(rs_data), 32'd1);
        do_op(OP_READ, 2, 4, 1'b0, 0, 0);
        check("rd_empty_data", 32'(r_data), 32'd0);

        // STEP on a blinker, then on a block.
        clear_grid();
        put(3, 2); put(3, 3); put(3, 4);
        do_op(OP_STEP, 0, 0, 1'b0, 0, 0);
        check("step_blink_proc", 32'(proc), 32'd1);
        check("step_blink_gens", 32'(r_gens), 32'd1);
        check("step_blink_stable", 32'(r_stable), 32'd0);
        check("step_blink_lat", 32'(lat), 32'd2);
        do_op(OP_READ, 2, 3, 1'b0, 0, 0);
        check("step_blink_rd23", 32'(r_data), 32'd1);
        do_op(OP_READ, 3, 2, 1'b0, 0, 0);
        check("step_blink_rd32", 32'(r_data), 32'd0);
        clear_grid();
        put(1, 1); put(1, 2); put(2, 1); put(2, 2);
        do_op(OP_STEP, 0, 0, 1'b0, 0, 0);
        check("step_block_stable", 32'(r_stable), 32'd1);
        check("step_block_gens", 32'(r_gens), 32'd1);

        // RUN: limit reached on a glider, early stop on a block, both at once.
        clear_grid();
        put(0, 1); put(1, 2); put(2, 0); put(2, 1); put(2, 2);
        do_op(OP_RUN, 0, 0, 1'b0, 5, 0);
        check("run_glider_proc", 32'(proc), 32'd5);
        check("run_glider_gaps", 32'(gaps), 32'd0);
        check("run_glider_gens", 32'(r_gens), 32'd5);
        check("run_glider_stable", 32'(r_stable), 32'd0);
        check("run_glider_lat", 32'(lat), 32'd6);
        clear_grid();
        put(4, 4); put(4, 5); put(5, 4); put(5, 5);
        do_op(OP_RUN, 0, 0, 1'b0, 100, 0);
        check("run_block_proc", 32'(proc), 32'd1);
        check("run_block_gens", 32'(r_gens), 32'd1);
        check("run_block_stable", 32'(r_stable), 32'd1);
        check("run_block_lat", 32'(lat), 32'd2);
        do_op(OP_RUN, 0, 0, 1'b0, 1, 0);
        check("run_both_gens", 32'(r_gens), 32'd1);
        check("run_both_stable", 32'(r_stable), 32'd1);
        clear_grid();
        put(3, 2); put(3, 3); put(3, 4);
        do_op(OP_RUN, 0, 0, 1'b0, 3, 0);
        check("run_blink_proc", 32'(proc), 32'd3);
        check("run_blink_gens", 32'(r_gens), 32'd3);
        check("run_blink_stable", 32'(r_stable), 32'd0);

        // RUN of zero generations and out-of-range targets (6x6 instance).
        do_op(OP_RUN, 0, 0, 1'b0, 0, 0);
        check("run0_proc", 32'(proc), 32'd0);
        check("run0_gens", 32'(r_gens), 32'd0);
        check("run0_stable", 32'(r_stable), 32'd0);
        check("run0_lat", 32'(lat), 32'd1);
        do_op(OP_READ, 7, 2, 1'b0, 0, 0);
        check("oor_rd_cmd", 32'(fs_cmd), 32'(C_READ));
        check("oor_rd_rsel", 32'(fs_rsel), 32'd0);
        check("oor_rd_csel", 32'(fs_csel), 32'd0);
        check("oor_rd_err", 32'(rs_err), 32'd1);
        check("oor_rd_data", 32'(rs_data), 32'd0);
        check("oor_rd_main_err", 32'(r_err), 32'd0);
        do_op(OP_WRITE, 1, 6, 1'b1, 0, 0);
        check("oor_wr_err", 32'(rs_err), 32'd1);
        check("oor_wr_csel", 32'(fs_csel), 32'd0);
        check("oor_wr_main_csel", 32'(f_csel), 32'h40);

        // Response held under back-pressure.
        clear_grid();
        put(4, 4);
        do_op(OP_READ, 4, 4, 1'b0, 0, 10);
        check("hold_unstable", 32'(unstable), 32'd0);
        check("hold_data", 32'(r_data), 32'd1);
        check("hold_after_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("hold_after_ready", 32'(host_ready), 32'd1);

        // Reset in the middle of a long RUN on an oscillator.
        clear_grid();
        put(3, 2); put(3, 3); put(3, 4);
        @(negedge clk);
        host_op = OP_RUN; host_gens = 16'd1000; host_valid = 1'b1;
        @(posedge clk); #1;
        host_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_run_cmd", 32'(pe_cmd), 32'(C_PROC));
        check("mid_run_ready", 32'(host_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_cmd", 32'(pe_cmd), 32'(C_NOP));
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_ready", 32'(host_ready), 32'd1);
        check("mid_rst_no_resp", 32'(resp_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
